// File: rtl/oric_tap_player.sv
// rtl/oric_tap_player.sv - .TAP capture into tape RAM and Oric fast-format cassette playback
module oric_tap_player #(
  parameter int ADDR_W    = 16,
  parameter int HALF_CYC  = 9984,
  parameter int STOP_BITS = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              play,
  input  logic              stop,
  input  logic              motor,
  output logic              tape_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   tap_len
);

  // start bit + 8 data bits + parity + stop bits
  localparam int FRAME_LEN = 10 + STOP_BITS;
  localparam int CNT_W     = $clog2(2 * HALF_CYC);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  SHORT_END = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0]  LONG_END  = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   ONE_LEN   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_BIT} state_t;

  state_t               state, state_nxt;
  logic                 dl_q;
  logic                 done_nxt;
  logic [CNT_W-1:0]     hcnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [FRAME_LEN-1:0] frame;
  logic [ADDR_W:0]      rd_ptr;

  logic                 dl_rise;
  logic                 load_wr;
  logic [ADDR_W:0]      wr_len;
  logic [ADDR_W:0]      rd_inc;
  logic                 last_byte;
  logic [CNT_W-1:0]     low_end;
  logic                 bit_end;
  logic                 byte_end;

  assign dl_rise   = dl_active & ~dl_q;
  assign load_wr   = (state == S_LOAD) & dl_active & dl_wr;
  assign wr_len    = {1'b0, dl_addr} + ONE_LEN;
  assign rd_inc    = rd_ptr + ONE_LEN;
  assign last_byte = (rd_inc == tap_len);
  // a '1' has a short low phase, a '0' a long one; the high phase is always short
  assign low_end   = frame[bit_idx] ? SHORT_END : LONG_END;
  assign bit_end   = (state == S_BIT) & motor & ~tape_out & (hcnt == low_end);
  assign byte_end  = bit_end & (bit_idx == LAST_IDX);

  // state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state, done request and RAM port muxing
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    busy      = (state != S_IDLE);
    mem_we    = 1'b0;
    mem_addr  = rd_ptr[ADDR_W-1:0];
    mem_wdata = 8'h00;
    if (load_wr) begin
      mem_we    = 1'b1;
      mem_addr  = dl_addr;
      mem_wdata = dl_data;
    end
    if (dl_rise) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE: begin
          if (play && !stop) begin
            if (tap_len != '0) state_nxt = S_FETCH;
            else               done_nxt  = 1'b1;
          end
        end
        S_LOAD:  if (!dl_active) state_nxt = S_IDLE;
        S_FETCH: state_nxt = stop ? S_IDLE : S_WAIT;
        S_WAIT:  state_nxt = stop ? S_IDLE : S_BIT;
        S_BIT: begin
          if (stop) begin
            state_nxt = S_IDLE;
          end else if (byte_end) begin
            state_nxt = last_byte ? S_IDLE : S_FETCH;
            done_nxt  = last_byte;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // image length, read pointer, frame and bit-timing datapath
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q     <= 1'b0;
      done     <= 1'b0;
      tap_len  <= '0;
      rd_ptr   <= '0;
      tape_out <= 1'b0;
      hcnt     <= '0;
      bit_idx  <= '0;
      frame    <= '0;
    end else begin
      dl_q <= dl_active;
      done <= done_nxt;
      if (dl_rise) begin
        tap_len  <= '0;
        rd_ptr   <= '0;
        tape_out <= 1'b0;
        hcnt     <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          S_LOAD: begin
            if (load_wr && wr_len > tap_len) tap_len <= wr_len;
            if (!dl_active) rd_ptr <= '0;
          end
          S_FETCH: if (stop) rd_ptr <= '0;
          S_WAIT: begin
            if (stop) begin
              rd_ptr <= '0;
            end else begin
              frame    <= {{STOP_BITS{1'b1}}, ~^mem_rdata, mem_rdata, 1'b0};
              hcnt     <= '0;
              bit_idx  <= '0;
              tape_out <= 1'b1;
            end
          end
          S_BIT: begin
            if (stop) begin
              rd_ptr   <= '0;
              tape_out <= 1'b0;
              hcnt     <= '0;
              bit_idx  <= '0;
            end else if (motor) begin
              if (tape_out) begin
                if (hcnt == SHORT_END) begin
                  hcnt     <= '0;
                  tape_out <= 1'b0;
                end else begin
                  hcnt <= hcnt + CNT_ONE;
                end
              end else if (hcnt == low_end) begin
                hcnt <= '0;
                if (bit_idx == LAST_IDX) begin
                  rd_ptr <= last_byte ? '0 : rd_inc;
                end else begin
                  bit_idx  <= bit_idx + IDX_ONE;
                  tape_out <= 1'b1;
                end
              end else begin
                hcnt <= hcnt + CNT_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
